// File: rtl/feature_frame_buffer.sv
// feature_frame_buffer: double-banked sample-to-frame collector that issues frames to a detector with done/timeout handshake
module feature_frame_buffer #(
  parameter int N_SAMPLES    = 30,
  parameter int W            = 10,
  parameter int SAT_MAX      = 999,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic [W-1:0] frame_out [N_SAMPLES],
  output logic         start,
  input  logic         det_done,
  output logic [7:0]   frame_count,
  output logic         timeout
);
  localparam int IW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
  localparam int TW = DONE_TIMEOUT > 1 ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] SAT = W'(SAT_MAX);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  fill_q [N_SAMPLES];
  logic [W-1:0]  fill_d [N_SAMPLES];
  logic [W-1:0]  frame_q [N_SAMPLES];
  logic [IW-1:0] wr_idx_q;
  logic          fill_full_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    count_q;
  logic          timeout_q, timeout_d;
  logic          accept, last, swap;
  assign sample_ready = !fill_full_q;
  assign start        = state_q == BUSY;
  assign frame_out    = frame_q;
  assign frame_count  = count_q;
  assign timeout      = timeout_q;
  // Fill bank as it will look after this cycle's write; a swap copies this so the final sample lands in the issued frame without delay
  always_comb begin
    accept = sample_valid && !fill_full_q;
    last   = accept && wr_idx_q == IW'(N_SAMPLES - 1);
    fill_d = fill_q;
    if (accept) fill_d[wr_idx_q] = sample_in > SAT ? SAT : sample_in;
  end
  // Issue FSM: swap from IDLE only, so a freshly idle cycle always separates two frames
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    swap      = 1'b0;
    if (state_q == IDLE) begin
      swap = fill_full_q || last;
      if (swap) begin
        state_d = BUSY;
        cnt_d   = '0;
      end
    end else if (det_done) begin
      state_d = IDLE;
    end else if (cnt_q == TW'(DONE_TIMEOUT - 1)) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end
  // State, bank and counter registers
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
      wr_idx_q    <= '0;
      fill_full_q <= 1'b0;
      fill_q      <= '{default: '0};
      frame_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      fill_q    <= fill_d;
      if (accept) wr_idx_q <= last ? '0 : wr_idx_q + IW'(1);
      if (swap) begin
        frame_q     <= fill_d;
        count_q     <= count_q + 8'd1;
        fill_full_q <= 1'b0;
      end else if (last) begin
        fill_full_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_feature_frame_buffer.sv
// tb_feature_frame_buffer: randomized scenario bench for feature_frame_buffer against a queue-based frame model
module tb_feature_frame_buffer;
  localparam int N  = 30;
  localparam int W  = 10;
  localparam int TO = 4095;
  logic         Clock, Rst, sample_valid, det_done;
  logic [W-1:0] sample_in;
  logic         sample_ready, start, timeout;
  logic [W-1:0] frame_out [N];
  logic [7:0]   frame_count;
  int           checks, failures;
  logic [W-1:0] q [$];
  logic [W-1:0] exp_hold [N];
  logic [7:0]   model_cnt;

  feature_frame_buffer dut (
    .Clock(Clock), .Rst(Rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_out(frame_out), .start(start),
    .det_done(det_done), .frame_count(frame_count), .timeout(timeout)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W-1:0] sat(input logic [W-1:0] v);
    return v > 10'd999 ? 10'd999 : v;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1;
    sample_valid = 0;
    det_done = 0;
    tick();
    tick();
    Rst = 0;
    q.delete();
    model_cnt = 0;
  endtask

  task automatic push_sample(input logic [W-1:0] v, input bit gaps);
    int n;
    if (gaps && $urandom_range(3) == 0) begin
      sample_valid = 0;
      tick();
    end
    sample_in = v;
    sample_valid = 1;
    n = 0;
    while (!sample_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n == 5000) begin
      checks++;
      failures++;
      $display("FAIL push_ready: sample_ready=%0b never rose, want 1", sample_ready);
    end else begin
      q.push_back(sat(v));
      tick();
    end
  endtask

  task automatic stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) push_sample(W'($urandom_range(1023)), gaps);
    sample_valid = 0;
  endtask

  task automatic check_frame(input string name);
    int bad;
    bad = 0;
    model_cnt++;
    for (int i = 0; i < N; i++) if (i >= q.size() || frame_out[i] !== q[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s frame: %0d entries differ, got [0]=%0d [29]=%0d want [0]=%0d [29]=%0d",
               name, bad, frame_out[0], frame_out[N-1], q.size() > 0 ? q[0] : 0, q.size() >= N ? q[N-1] : 0);
    end
    for (int i = 0; i < N; i++) exp_hold[i] = q.size() > 0 ? q.pop_front() : '0;
    checks++;
    if (start !== 1'b1) begin failures++; $display("FAIL %s start: got %b want 1", name, start); end
    checks++;
    if (frame_count !== model_cnt) begin failures++; $display("FAIL %s count: got %0d want %0d", name, frame_count, model_cnt); end
  endtask

  task automatic finish_frame(input string name, input int dly);
    int bad;
    bad = 0;
    for (int k = 0; k < dly; k++) begin
      tick();
      if (start !== 1'b1) bad++;
      for (int i = 0; i < N; i++) if (frame_out[i] !== exp_hold[i]) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s hold: %0d deviations, want 0", name, bad); end
    det_done = 1;
    tick();
    det_done = 0;
    checks++;
    if (start !== 1'b0) begin failures++; $display("FAIL %s done_drop: start=%b want 0", name, start); end
  endtask

  task automatic test_reset;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < N; i++) if (frame_out[i] !== '0) bad++;
    checks++;
    if (bad != 0 || start !== 1'b0 || timeout !== 1'b0 || frame_count !== 8'd0 || sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: start=%b timeout=%b count=%0d ready=%b nonzero=%0d want 0 0 0 1 0",
               start, timeout, frame_count, sample_ready, bad);
    end
    det_done = 1;
    repeat (3) tick();
    det_done = 0;
    checks++;
    if (start !== 1'b0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL idle_done: start=%b count=%0d want 0 0", start, frame_count);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] v [N];
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(998));
    v[0] = 10'd284;
    v[1] = 10'd281;
    v[N-1] = 10'd295;
    for (int i = 0; i < N; i++) push_sample(v[i], 0);
    sample_valid = 0;
    checks++;
    if (frame_out[0] !== 10'd284 || frame_out[N-1] !== 10'd295) begin
      failures++;
      $display("FAIL basic_ends: got %0d %0d want 284 295", frame_out[0], frame_out[N-1]);
    end
    check_frame("basic");
    finish_frame("basic", 2);
    tick();
  endtask

  task automatic test_saturation;
    int a, b;
    a = $urandom_range(N - 1);
    b = (a + 1 + $urandom_range(N - 2)) % N;
    for (int i = 0; i < N; i++) push_sample(i == a ? 10'd1023 : i == b ? 10'd0 : W'($urandom_range(1023)), 1);
    sample_valid = 0;
    checks++;
    if (frame_out[a] !== 10'd999 || frame_out[b] !== 10'd0) begin
      failures++;
      $display("FAIL sat: got %0d %0d want 999 0", frame_out[a], frame_out[b]);
    end
    check_frame("sat");
    finish_frame("sat", $urandom_range(5));
    tick();
  endtask

  task automatic test_back_to_back;
    stream(N, 0);
    check_frame("b2b_a");
    stream(N, 0);
    sample_valid = 1;
    sample_in = 10'd7;
    repeat (3) tick();
    sample_valid = 0;
    checks++;
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall: ready=%b want 0", sample_ready); end
    finish_frame("b2b_a", 2);
    checks++;
    if (sample_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap_ready: ready=%b want 0", sample_ready); end
    tick();
    check_frame("b2b_b");
    checks++;
    if (sample_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: ready=%b want 1", sample_ready); end
    finish_frame("b2b_b", 1);
    tick();
  endtask

  task automatic test_same_cycle;
    stream(N, 1);
    check_frame("same_a");
    stream(N - 1, 1);
    det_done = 1;
    push_sample(W'($urandom_range(1023)), 0);
    det_done = 0;
    sample_valid = 0;
    checks++;
    if (start !== 1'b0 || sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL same_gap: start=%b ready=%b want 0 0", start, sample_ready);
    end
    tick();
    check_frame("same_b");
    finish_frame("same_b", 0);
    tick();
  endtask

  task automatic test_timeout;
    int seen, pulses;
    stream(N, 0);
    check_frame("to");
    seen = -1;
    pulses = 0;
    for (int k = 1; k <= TO + 3; k++) begin
      tick();
      if (timeout === 1'b1) begin
        pulses++;
        if (seen < 0) seen = k;
        checks++;
        if (start !== 1'b0) begin failures++; $display("FAIL to_start: start=%b want 0", start); end
      end
    end
    checks++;
    if (seen != TO || pulses != 1) begin
      failures++;
      $display("FAIL to_pulse: first at %0d count %0d want %0d count 1", seen, pulses, TO);
    end
  endtask

  task automatic test_midreset;
    int bad;
    stream(12, 0);
    do_reset();
    checks++;
    if (sample_ready !== 1'b1 || start !== 1'b0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_rst: ready=%b start=%b count=%0d want 1 0 0", sample_ready, start, frame_count);
    end
    stream(N, 1);
    check_frame("mid_new");
    stream(10, 0);
    do_reset();
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (start !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || frame_count !== 8'd0) begin
      failures++;
      $display("FAIL busy_rst: start high %0d cycles count=%0d want 0 0", bad, frame_count);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int f = 0; f < 256; f++) begin
      stream(N, 1);
      check_frame("wrap");
      finish_frame("wrap", $urandom_range(2));
    end
    checks++;
    if (frame_count !== 8'd0) begin failures++; $display("FAIL wrap_zero: count=%0d want 0", frame_count); end
  endtask

  initial begin
    Clock = 0;
    Rst = 1;
    sample_in = '0;
    sample_valid = 0;
    det_done = 0;
    checks = 0;
    failures = 0;
    model_cnt = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_same_cycle();
    test_timeout();
    test_midreset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/feature_frame_buffer.md
FEATURE_FRAME_BUFFER -- requirements
Module: feature_frame_buffer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 30, samples per frame.
REQ-002 SHALL have parameter W, default 10, sample width in bits.
REQ-003 SHALL have parameter SAT_MAX, default 999, clamp ceiling for stored samples.
REQ-004 SHALL have parameter DONE_TIMEOUT, default 4095, max cycles to wait for det_done.
REQ-005 SHALL have port Clock, input, 1, the single clock; every register updates on its rising edge.
REQ-006 SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port sample_in, input, W, serial feature sample.
REQ-008 SHALL have port sample_valid, input, 1, sample_in is valid.
REQ-009 SHALL have port sample_ready, output, 1, block can accept a sample.
REQ-010 SHALL have port frame_out, output, N_SAMPLES x W unpacked array, frame presented to the detector; index 0 holds the first sample.
REQ-011 SHALL have port start, output, 1, a frame is in flight to the detector.
REQ-012 SHALL have port det_done, input, 1, detector finished the current frame.
REQ-013 SHALL have port frame_count, output, 8, count of frames issued.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse when a frame is abandoned.

Function
REQ-015 SHALL accept a sample in any cycle where sample_valid and sample_ready are both 1.
REQ-016 SHALL hold two banks: a fill bank written by accepted samples and an issue bank driven onto frame_out.
REQ-017 SHALL write each accepted sample to fill bank index wr_idx, then increment wr_idx; wr_idx wraps N_SAMPLES-1 -> 0 and sets fill_full.
REQ-018 SHALL store min(sample_in, SAT_MAX); zero samples are stored unchanged.
REQ-019 SHALL drive sample_ready = NOT fill_full.
REQ-020 SHALL implement issue FSM states IDLE and BUSY.
REQ-021 In IDLE with fill_full=1, SHALL swap banks, clear fill_full, raise start, increment frame_count (8-bit wrap 255 -> 0), and enter BUSY, all in one edge.
REQ-022 Latency: when the last sample of a frame is accepted in cycle t and the FSM is IDLE, SHALL have start=1 and the new frame on frame_out in cycle t+1.
REQ-023 SHALL hold frame_out constant for the whole time start=1.
REQ-024 In BUSY, SHALL sample det_done; when det_done=1, SHALL drop start on the next edge and return to IDLE.
REQ-025 SHALL ignore det_done while in IDLE.
REQ-026 SHALL count BUSY cycles; when the count reaches DONE_TIMEOUT without det_done, SHALL pulse timeout for one cycle, drop start, and return to IDLE.
REQ-027 After returning to IDLE, SHALL keep start=0 for at least one cycle before the next swap, even if fill_full=1.
REQ-028 SHALL let the fill bank keep accepting samples while BUSY; the fill bank stalls only when fill_full=1.
REQ-029 If the final sample is accepted in the same cycle det_done is seen, SHALL apply both events; the swap occurs after the mandatory one-cycle start-low gap.
REQ-030 SHALL never let a swap overwrite the issue bank while start=1.

Reset
REQ-031 On Rst=1 at a rising edge, SHALL set start=0, timeout=0, frame_count=0, wr_idx=0, fill_full=0, FSM=IDLE, and all frame_out entries to 0.
REQ-032 SHALL drive sample_ready=1 in the first cycle after Rst deasserts.
REQ-033 On reset mid-frame or mid-BUSY, SHALL discard the partial fill and any in-flight frame; no start pulse follows from pre-reset data.

Verification
REQ-034 Stream 30 samples 284, 281, ..., 295 with continuous valid -> start=1 one cycle after the 30th sample; frame_out[0]=284; frame_out[29]=295; frame_count=1.
REQ-035 Send sample 1023 and sample 0 within a frame -> stored values are 999 and 0.
REQ-036 Keep det_done=0 after start, fill a second frame, keep valid=1 -> sample_ready=0 after the 30th sample of the second frame; raising det_done -> start low for 1 cycle, then high with the second frame, and sample_ready=1.
REQ-037 Never assert det_done -> timeout pulses exactly DONE_TIMEOUT cycles after start rises; start=0 the same cycle.
REQ-038 Assert Rst after 12 samples, then stream 30 new samples -> the first frame contains only post-reset samples and frame_count=1.
REQ-039 Issue 256 frames -> frame_count wraps to 0.
